// File: rtl/binning_ctrl.sv
// Frame-synchronous mode controller for the cascaded 2x2 binning stages.
// Mode changes land only between frames after a drain guard; input geometry is measured per frame.
module binning_ctrl #(
  parameter int LINE_SIZE_MAX = 4096,
  parameter int FRAME_H_MAX   = 4096,
  parameter int GUARD_CYCLES  = 1024,
  localparam int CW           = $clog2(LINE_SIZE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode_req,
  input  logic          mode_req_vld,
  input  logic          de_i,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          err_clr,
  output logic          bypass0_o,
  output logic          bypass1_o,
  output logic [1:0]    sel_o,
  output logic [1:0]    mode_o,
  output logic          pending_o,
  output logic [CW-1:0] frame_w_o,
  output logic [CW-1:0] frame_h_o,
  output logic [CW-1:0] out_w_o,
  output logic [CW-1:0] out_h_o,
  output logic [2:0]    err_o
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0] PIX_MAX    = CW'(LINE_SIZE_MAX);
  localparam logic [CW-1:0] LINE_MAX   = CW'(FRAME_H_MAX);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_FRAME, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    pend_mode_q, pend_mode_d;
  logic          pending_q, pending_d;
  logic          byp0_q, byp0_d;
  logic          byp1_q, byp1_d;
  logic [CW-1:0] pix_q, pix_d;
  logic [CW-1:0] line_q, line_d;
  logic [CW-1:0] ref_w_q, ref_w_d;
  logic          ref_vld_q, ref_vld_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [CW-1:0] frame_w_q, frame_w_d;
  logic [CW-1:0] frame_h_q, frame_h_d;
  logic [CW-1:0] out_w_q, out_w_d;
  logic [CW-1:0] out_h_q, out_h_d;
  logic [2:0]    err_q, err_d;
  logic          hs_prev_q;
  logic          req_ok;
  logic          line_close;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pending_d   = pending_q;
    pix_d       = pix_q;
    line_d      = line_q;
    ref_w_d     = ref_w_q;
    ref_vld_d   = ref_vld_q;
    guard_d     = guard_q;
    frame_w_d   = frame_w_q;
    frame_h_d   = frame_h_q;
    out_w_d     = out_w_q;
    out_h_d     = out_h_q;
    err_d       = err_clr ? 3'b000 : err_q;
    line_close  = 1'b0;
    req_ok      = mode_req_vld && (mode_req != 2'd3);

    if (mode_req_vld && (mode_req == 2'd3)) err_d[2] = 1'b1;
    if (req_ok) begin
      pend_mode_d = mode_req;
      pending_d   = 1'b1;
    end

    case (state_q)
      S_SYNC: if (!vs_i) state_d = S_IDLE;
      S_IDLE: begin
        // A strobe this cycle is already folded into pend_mode_d, so it is applied too.
        if (pending_d) begin
          mode_d    = pend_mode_d;
          pending_d = 1'b0;
        end
        if (vs_i) begin
          state_d   = S_FRAME;
          pix_d     = '0;
          line_d    = '0;
          ref_w_d   = '0;
          ref_vld_d = 1'b0;
        end
      end
      S_FRAME: begin
        if (!vs_i) begin
          line_close = !hs_i && (pix_q != '0);
          state_d    = S_DRAIN;
          guard_d    = '0;
        end else if (hs_i && !hs_prev_q) begin
          line_close = (pix_q != '0);
        end else if (de_i && !hs_i && (pix_q != PIX_MAX)) begin
          pix_d = pix_q + CW'(1);
        end
        if (line_close) begin
          pix_d = '0;
          if (line_q != LINE_MAX) line_d = line_q + CW'(1);
          if (!ref_vld_q) begin
            ref_w_d   = pix_q;
            ref_vld_d = 1'b1;
          end else if (pix_q != ref_w_q) begin
            err_d[0] = 1'b1;
          end
        end
        // Report uses the _d values so a line closed by the vs fall is included.
        if (!vs_i) begin
          frame_w_d = ref_w_d;
          frame_h_d = line_d;
          out_w_d   = ref_w_d >> mode_q;
          out_h_d   = line_d >> mode_q;
        end
      end
      S_DRAIN: begin
        if (vs_i) begin
          state_d   = S_FRAME;
          err_d[1]  = 1'b1;
          pix_d     = '0;
          line_d    = '0;
          ref_w_d   = '0;
          ref_vld_d = 1'b0;
        end else if (guard_q == GUARD_LAST) begin
          state_d = S_IDLE;
          if (pending_d) begin
            mode_d    = pend_mode_d;
            pending_d = 1'b0;
          end
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase

    byp0_d = (mode_d == 2'd0);
    byp1_d = (mode_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC;
      mode_q      <= 2'd0;
      pend_mode_q <= 2'd0;
      pending_q   <= 1'b0;
      byp0_q      <= 1'b1;
      byp1_q      <= 1'b1;
      pix_q       <= '0;
      line_q      <= '0;
      ref_w_q     <= '0;
      ref_vld_q   <= 1'b0;
      guard_q     <= '0;
      frame_w_q   <= '0;
      frame_h_q   <= '0;
      out_w_q     <= '0;
      out_h_q     <= '0;
      err_q       <= 3'b000;
      hs_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pending_q   <= pending_d;
      byp0_q      <= byp0_d;
      byp1_q      <= byp1_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      ref_w_q     <= ref_w_d;
      ref_vld_q   <= ref_vld_d;
      guard_q     <= guard_d;
      frame_w_q   <= frame_w_d;
      frame_h_q   <= frame_h_d;
      out_w_q     <= out_w_d;
      out_h_q     <= out_h_d;
      err_q       <= err_d;
      hs_prev_q   <= hs_i;
    end
  end

  assign bypass0_o = byp0_q;
  assign bypass1_o = byp1_q;
  assign sel_o     = mode_q;
  assign mode_o    = mode_q;
  assign pending_o = pending_q;
  assign frame_w_o = frame_w_q;
  assign frame_h_o = frame_h_q;
  assign out_w_o   = out_w_q;
  assign out_h_o   = out_h_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_binning_ctrl.sv
// Bench for binning_ctrl: directed scenarios plus random frames, checked every cycle
// against a frame-level behavioural model, with literal expectations pinning the model.
module tb_binning_ctrl;
  localparam int LMAX = 64;
  localparam int HMAX = 32;
  localparam int G    = 16;
  localparam int CW   = $clog2(LMAX + 1);

  localparam int PH_SYNC  = 0;
  localparam int PH_IDLE  = 1;
  localparam int PH_FRAME = 2;
  localparam int PH_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode_req;
  logic          mode_req_vld;
  logic          de_i, hs_i, vs_i, err_clr;
  logic          bypass0_o, bypass1_o, pending_o;
  logic [1:0]    sel_o, mode_o;
  logic [CW-1:0] frame_w_o, frame_h_o, out_w_o, out_h_o;
  logic [2:0]    err_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  binning_ctrl #(.LINE_SIZE_MAX(LMAX), .FRAME_H_MAX(HMAX), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .mode_req(mode_req), .mode_req_vld(mode_req_vld),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .err_clr(err_clr),
    .bypass0_o(bypass0_o), .bypass1_o(bypass1_o), .sel_o(sel_o), .mode_o(mode_o),
    .pending_o(pending_o), .frame_w_o(frame_w_o), .frame_h_o(frame_h_o),
    .out_w_o(out_w_o), .out_h_o(out_h_o), .err_o(err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       m_phase, m_mode, m_pend_mode, m_cur, m_drain;
  bit       m_pend, m_hs_prev;
  logic [2:0] m_err;
  int       m_fw, m_fh, m_ow, m_oh;
  int       m_lines[$];

  function automatic void m_close_line();
    m_lines.push_back(m_cur);
    if (m_lines.size() > 1 && m_cur != m_lines[0]) m_err[0] = 1'b1;
    m_cur = 0;
  endfunction

  function automatic void m_report();
    m_fw = (m_lines.size() > 0) ? m_lines[0] : 0;
    m_fh = (m_lines.size() < HMAX) ? m_lines.size() : HMAX;
    m_ow = m_fw >> m_mode;
    m_oh = m_fh >> m_mode;
  endfunction

  function automatic void m_new_frame();
    m_phase = PH_FRAME;
    m_cur   = 0;
    m_lines.delete();
  endfunction

  always @(posedge clk) begin : model
    bit req_ok;
    if (rst) begin
      m_phase = PH_SYNC; m_mode = 0; m_pend = 0; m_pend_mode = 0; m_err = 3'b000;
      m_fw = 0; m_fh = 0; m_ow = 0; m_oh = 0; m_cur = 0; m_drain = 0; m_hs_prev = 0;
      m_lines.delete();
    end else begin
      if (err_clr) m_err = 3'b000;
      if (mode_req_vld && mode_req == 2'd3) m_err[2] = 1'b1;
      req_ok = mode_req_vld && mode_req != 2'd3;
      if (req_ok) begin m_pend = 1; m_pend_mode = int'(mode_req); end
      case (m_phase)
        PH_SYNC: if (!vs_i) m_phase = PH_IDLE;
        PH_IDLE: begin
          if (m_pend) begin m_mode = m_pend_mode; m_pend = 0; end
          if (vs_i) m_new_frame();
        end
        PH_FRAME: begin
          if (!vs_i) begin
            if (!hs_i && m_cur > 0) m_close_line();
            m_report();
            m_phase = PH_DRAIN;
            m_drain = 0;
          end else if (hs_i && !m_hs_prev) begin
            if (m_cur > 0) m_close_line();
          end else if (de_i && !hs_i) begin
            m_cur = (m_cur < LMAX) ? m_cur + 1 : LMAX;
          end
        end
        default: begin
          if (vs_i) begin
            m_err[1] = 1'b1;
            m_new_frame();
          end else begin
            m_drain++;
            if (m_drain == G) begin
              m_phase = PH_IDLE;
              if (m_pend) begin m_mode = m_pend_mode; m_pend = 0; end
            end
          end
        end
      endcase
      m_hs_prev = hs_i;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mode_o",    32'(mode_o),    32'(m_mode));
      chk("sel_o",     32'(sel_o),     32'(m_mode));
      chk("bypass0_o", 32'(bypass0_o), 32'(m_mode == 0));
      chk("bypass1_o", 32'(bypass1_o), 32'(m_mode != 2));
      chk("pending_o", 32'(pending_o), 32'(m_pend));
      chk("frame_w_o", 32'(frame_w_o), 32'(m_fw));
      chk("frame_h_o", 32'(frame_h_o), 32'(m_fh));
      chk("out_w_o",   32'(out_w_o),   32'(m_ow));
      chk("out_h_o",   32'(out_h_o),   32'(m_oh));
      chk("err_o",     32'(err_o),     32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic h, input logic d);
    vs_i = v; hs_i = h; de_i = d;
    @(negedge clk);
    mode_req_vld = 1'b0;
    err_clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        mode_req = 2'($urandom_range(0, 3)); mode_req_vld = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) err_clr = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic send_frame(input int lines, input int w, input int bad_line, input int bad_w,
                            input int req_line, input int req_mode, input bit close_open,
                            input int de_pct);
    int  lw;
    logic d;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int l = 0; l < lines; l++) begin
      lw = (l == bad_line) ? bad_w : w;
      if (l == req_line) begin mode_req = 2'(req_mode); mode_req_vld = 1'b1; end
      for (int p = 0; p < lw; p++) begin
        d = (de_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < de_pct);
        cyc(1'b1, 1'b0, d);
      end
      if (!(close_open && l == lines - 1)) repeat (3) cyc(1'b1, 1'b1, 1'b0);
    end
    if (close_open) cyc(1'b0, 1'b0, 1'b0);
    else            cyc(1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_lines, w, bl, g;
    rst = 1'b1; mode_req = 2'd0; mode_req_vld = 1'b0; err_clr = 1'b0;
    de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    chk("rst mode",  32'(mode_o), 0);
    chk("rst byp0",  32'(bypass0_o), 1);
    chk("rst byp1",  32'(bypass1_o), 1);
    chk("rst err",   32'(err_o), 0);
    chk("rst width", 32'(frame_w_o), 0);
    rst = 1'b0;
    idle(2);

    // immediate apply while idle
    mode_req = 2'd2; mode_req_vld = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    chk("idle apply mode", 32'(mode_o), 2);
    chk("idle apply byp0", 32'(bypass0_o), 0);
    chk("idle apply byp1", 32'(bypass1_o), 0);
    chk("idle apply pend", 32'(pending_o), 0);

    // 28x28 in mode 2 with a mid-frame request for mode 1
    send_frame(28, 28, -1, 0, 5, 1, 1'b0, 100);
    chk("A frame_w", 32'(frame_w_o), 28);
    chk("A frame_h", 32'(frame_h_o), 28);
    chk("A out_w",   32'(out_w_o), 7);
    chk("A out_h",   32'(out_h_o), 7);
    chk("A pending", 32'(pending_o), 1);
    chk("A mode held", 32'(mode_o), 2);
    idle(G - 1);
    chk("guard not yet", 32'(mode_o), 2);
    idle(1);
    chk("guard applied", 32'(mode_o), 1);

    // mode 1 frame, then a frame that starts inside the drain guard
    send_frame(20, 20, -1, 0, 2, 0, 1'b0, 100);
    idle(10);
    chk("B out_w", 32'(out_w_o), 10);
    chk("B out_h", 32'(out_h_o), 10);
    send_frame(8, 12, -1, 0, -1, 0, 1'b0, 100);
    chk("C err drain", 32'(err_o[1]), 1);
    chk("C mode held", 32'(mode_o), 1);
    chk("C pending",   32'(pending_o), 1);
    chk("C out_w",     32'(out_w_o), 6);
    chk("C out_h",     32'(out_h_o), 4);
    idle(G);
    chk("C applied late", 32'(mode_o), 0);

    // width mismatch then clear
    err_clr = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    chk("clear err", 32'(err_o), 0);
    send_frame(24, 24, 5, 23, -1, 0, 1'b0, 100);
    chk("D err width", 32'(err_o), 1);
    chk("D frame_w",   32'(frame_w_o), 24);
    chk("D frame_h",   32'(frame_h_o), 24);
    err_clr = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    chk("D cleared", 32'(err_o), 0);
    idle(G);

    // vs falls inside an open line; saturation of both counters
    send_frame(10, 16, -1, 0, -1, 0, 1'b1, 100);
    chk("E frame_w", 32'(frame_w_o), 16);
    chk("E frame_h", 32'(frame_h_o), 10);
    idle(G + 2);
    send_frame(34, 70, -1, 0, -1, 0, 1'b0, 100);
    chk("F sat w", 32'(frame_w_o), 64);
    chk("F sat h", 32'(frame_h_o), 32);
    chk("F no err", 32'(err_o), 0);
    idle(G + 2);

    // reserved mode request, then reset mid-frame
    mode_req = 2'd3; mode_req_vld = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    chk("reserved err", 32'(err_o), 4);
    chk("reserved mode", 32'(mode_o), 0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (3) begin
      repeat (8) cyc(1'b1, 1'b0, 1'b1);
      repeat (2) cyc(1'b1, 1'b1, 1'b0);
    end
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    chk("midrst err",   32'(err_o), 0);
    chk("midrst width", 32'(frame_w_o), 0);
    repeat (5) cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    chk("sync ignores tail", 32'(frame_w_o), 0);
    idle(3);
    send_frame(9, 13, -1, 0, -1, 0, 1'b0, 100);
    chk("after rst w", 32'(frame_w_o), 13);
    chk("after rst h", 32'(frame_h_o), 9);

    // random frames
    for (int it = 0; it < 10; it++) begin
      do g = $urandom_range(3, G + 8); while (g == G - 1);
      gap(g);
      n_lines = $urandom_range(1, 36);
      w       = $urandom_range(1, 70);
      bl      = $urandom_range(0, n_lines + 3);
      send_frame(n_lines, w, bl, $urandom_range(1, 70), $urandom_range(0, n_lines),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? 100 : 70);
    end
    gap(G + 4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
